// File: rtl/cfu_issue_pkg.sv
// Shared types and widths for the CFU issue block.
package cfu_issue_pkg;

  localparam int XLEN         = 32;
  localparam int CFU_FUNCT3_W = 3;
  localparam int CFU_FUNCT7_W = 7;
  localparam int REG_IDX_W    = 5;

  typedef enum logic [2:0] {
    ST_DRAIN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/cfu_issue_wdog.sv
// Up-counter with clear/enable; expire_o flags the enabled cycle in which the count sits at tc_i.
module cfu_issue_wdog #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == tc_i);

endmodule

// File: rtl/cfu_issue.sv
// CPU-side CFU initiator: issues one custom op, waits for the result (with watchdog), hands it to writeback.
//   state | meaning
//   DRAIN | wait for DRAIN_QUIET consecutive idle CFU cycles before accepting work
//   IDLE  | ready for a request
//   ISSUE | cfu_en_o pulse, operands presented
//   WAIT  | CFU stalling, watchdog running
//   RESP  | response held until writeback accepts
module cfu_issue
  import cfu_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned DRAIN_QUIET    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [CFU_FUNCT3_W-1:0] req_funct3_i,
  input  logic [CFU_FUNCT7_W-1:0] req_funct7_i,
  input  logic [XLEN-1:0]         req_src1_i,
  input  logic [XLEN-1:0]         req_src2_i,
  input  logic [REG_IDX_W-1:0]    req_rd_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [XLEN-1:0]         rsp_data_o,
  output logic [REG_IDX_W-1:0]    rsp_rd_o,
  output logic                    rsp_err_o,
  output logic                    busy_o,
  output logic [31:0]             ops_cnt_o,
  output logic                    cfu_en_o,
  output logic [CFU_FUNCT3_W-1:0] cfu_funct3_o,
  output logic [CFU_FUNCT7_W-1:0] cfu_funct7_o,
  output logic [XLEN-1:0]         cfu_src1_o,
  output logic [XLEN-1:0]         cfu_src2_o,
  input  logic                    cfu_stall_i,
  input  logic [XLEN-1:0]         cfu_rslt_i
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam int unsigned DQ_W = $clog2(DRAIN_QUIET + 1) + 1;
  localparam logic [WD_W-1:0] WD_TC = (TIMEOUT_CYCLES == 0) ? WD_W'(0) : WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DQ_W-1:0] DQ_TC = (DRAIN_QUIET == 0) ? DQ_W'(0) : DQ_W'(DRAIN_QUIET - 1);
  localparam logic            WD_ON = (TIMEOUT_CYCLES != 0);

  state_e                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    busy_q, busy_d;
  logic                    cfu_en_q, cfu_en_d;
  logic [CFU_FUNCT3_W-1:0] f3_q, f3_d;
  logic [CFU_FUNCT7_W-1:0] f7_q, f7_d;
  logic [XLEN-1:0]         src1_q, src1_d;
  logic [XLEN-1:0]         src2_q, src2_d;
  logic [REG_IDX_W-1:0]    rd_q, rd_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]         rsp_data_q, rsp_data_d;
  logic [REG_IDX_W-1:0]    rsp_rd_q, rsp_rd_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [31:0]             ops_cnt_q, ops_cnt_d;

  logic wd_exp;
  logic quiet_exp;

  cfu_issue_wdog #(.W(WD_W)) u_wdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_q != ST_WAIT),
    .en_i     ((state_q == ST_WAIT) && cfu_stall_i && WD_ON),
    .tc_i     (WD_TC),
    .expire_o (wd_exp)
  );

  cfu_issue_wdog #(.W(DQ_W)) u_quiet (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    ((state_q != ST_DRAIN) || cfu_stall_i),
    .en_i     ((state_q == ST_DRAIN) && !cfu_stall_i),
    .tc_i     (DQ_TC),
    .expire_o (quiet_exp)
  );

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    f7_d       = f7_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    rd_d       = rd_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;
    rsp_err_d  = rsp_err_q;
    ops_cnt_d  = ops_cnt_q;

    case (state_q)
      ST_DRAIN: begin
        if (quiet_exp) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid_i) begin
          f3_d    = req_funct3_i;
          f7_d    = req_funct7_i;
          src1_d  = req_src1_i;
          src2_d  = req_src2_i;
          rd_d    = req_rd_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // a result arriving in the same cycle the watchdog fires is still taken
        if (!cfu_stall_i) begin
          rsp_data_d = cfu_rslt_i;
          rsp_err_d  = 1'b0;
          rsp_rd_d   = rd_q;
          state_d    = ST_RESP;
        end else if (wd_exp) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_rd_d   = rd_q;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = rsp_err_q ? ST_DRAIN : ST_IDLE;
          if (!rsp_err_q) ops_cnt_d = ops_cnt_q + 32'd1;
          f3_d       = '0;
          f7_d       = '0;
          src1_d     = '0;
          src2_d     = '0;
          rsp_data_d = '0;
          rsp_rd_d   = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = ST_DRAIN;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    cfu_en_d    = (state_d == ST_ISSUE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_DRAIN;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      cfu_en_q    <= 1'b0;
      f3_q        <= '0;
      f7_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      rd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
      ops_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      cfu_en_q    <= cfu_en_d;
      f3_q        <= f3_d;
      f7_q        <= f7_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_err_q   <= rsp_err_d;
      ops_cnt_q   <= ops_cnt_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign busy_o       = busy_q;
  assign cfu_en_o     = cfu_en_q;
  assign cfu_funct3_o = f3_q;
  assign cfu_funct7_o = f7_q;
  assign cfu_src1_o   = src1_q;
  assign cfu_src2_o   = src2_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_rd_o     = rsp_rd_q;
  assign rsp_err_o    = rsp_err_q;
  assign ops_cnt_o    = ops_cnt_q;

endmodule

// File: tb/tb_cfu_issue.sv
// Bench for cfu_issue: directed table, multi-cycle corner sequences and randomized ops vs. a latency/result model.
module tb_cfu_issue;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_funct3 = '0;
  logic [6:0]  req_funct7 = '0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic [4:0]  req_rd = '0;
  logic        rsp_valid_o;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_rd_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic [31:0] ops_cnt_o;
  logic        cfu_en_o;
  logic [2:0]  cfu_funct3_o;
  logic [6:0]  cfu_funct7_o;
  logic [31:0] cfu_src1_o;
  logic [31:0] cfu_src2_o;
  logic        cfu_stall;
  logic [31:0] cfu_rslt;

  cfu_issue #(.TIMEOUT_CYCLES(TMO), .DRAIN_QUIET(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_funct3_i (req_funct3),
    .req_funct7_i (req_funct7),
    .req_src1_i   (req_src1),
    .req_src2_i   (req_src2),
    .req_rd_i     (req_rd),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data_o),
    .rsp_rd_o     (rsp_rd_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o),
    .ops_cnt_o    (ops_cnt_o),
    .cfu_en_o     (cfu_en_o),
    .cfu_funct3_o (cfu_funct3_o),
    .cfu_funct7_o (cfu_funct7_o),
    .cfu_src1_o   (cfu_src1_o),
    .cfu_src2_o   (cfu_src2_o),
    .cfu_stall_i  (cfu_stall),
    .cfu_rslt_i   (cfu_rslt)
  );

  always #5 clk = ~clk;

  // Responder: funct3==0 is ADD, anything else returns 0; stall lasts resp_lat cycles starting at the issue cycle.
  int resp_lat = 0;
  int rem = 0;
  int en_cnt = 0;
  bit force_stall = 1'b0;

  always @(posedge clk) begin
    if (cfu_en_o) begin
      en_cnt <= en_cnt + 1;
      rem    <= (resp_lat > 0) ? resp_lat - 1 : 0;
    end else if (rem > 0) begin
      rem <= rem - 1;
    end
  end

  assign cfu_stall = force_stall || (cfu_en_o ? (resp_lat > 0) : (rem > 0));
  assign cfu_rslt  = (cfu_funct3_o == 3'd0) ? cfu_src1_o + cfu_src2_o : 32'd0;

  int n_tests = 0;
  int n_fail = 0;
  int exp_ops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, event not seen, event expected", name);
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic run_op(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [4:0] rd, input int lat, input int hold,
                        output logic [31:0] d, output logic [4:0] r, output logic e,
                        output int rl, output int ne, output bit ok);
    int k;
    int e0;
    d = '0; r = '0; e = 1'b0; rl = -1; ne = 0; ok = 1'b1;
    k = 0;
    while (req_ready_o !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (req_ready_o !== 1'b1) begin
      bound_fail("req_ready wait");
      return;
    end
    req_valid = 1'b1; req_funct3 = f3; req_funct7 = f7;
    req_src1 = s1; req_src2 = s2; req_rd = rd; resp_lat = lat;
    e0 = en_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (cfu_en_o !== 1'b1 || cfu_funct3_o !== f3 || cfu_funct7_o !== f7 ||
        cfu_src1_o !== s1 || cfu_src2_o !== s2 || req_ready_o !== 1'b0) ok = 1'b0;
    k = 1;
    while (rsp_valid_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (rsp_valid_o !== 1'b1) begin
      bound_fail("rsp_valid wait");
      return;
    end
    rl = k; d = rsp_data_o; r = rsp_rd_o; e = rsp_err_o;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== d || rsp_rd_o !== r || rsp_err_o !== e ||
          req_ready_o !== 1'b0 || cfu_en_o !== 1'b0) ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid_o !== 1'b0) ok = 1'b0;
    ne = en_cnt - e0;
  endtask

  task automatic check_op(input string tag, input logic [31:0] d, input logic [4:0] r, input logic e,
                          input int rl, input int ne, input bit ok, input logic [31:0] xd,
                          input logic [4:0] xr, input logic xe, input int xl);
    chk({tag, " data"}, d, xd);
    chk({tag, " rd"}, {27'd0, r}, {27'd0, xr});
    chk({tag, " err"}, {31'd0, e}, {31'd0, xe});
    chk({tag, " latency"}, rl, xl);
    chk({tag, " en pulses"}, ne, 32'd1);
    chk({tag, " hold/handshake"}, {31'd0, ok}, 32'd1);
    if (!xe) exp_ops++;
    chk({tag, " ops_cnt"}, ops_cnt_o, exp_ops);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  rd;
    int          lat;
    int          hold;
    logic [31:0] xd;
    logic        xe;
    int          xl;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] d;
    logic [4:0]  r;
    logic        e;
    int          rl, ne, k, seen;
    bit          ok;

    tbl[0] = '{3'd0, 7'h00, 32'd5,          32'd7,          5'd3,  2, 0, 32'd12,         1'b0, 4};
    tbl[1] = '{3'd1, 7'h05, 32'd9,          32'd9,          5'd7,  0, 0, 32'd0,          1'b0, 2};
    tbl[2] = '{3'd0, 7'h00, 32'hFFFF_FFFF,  32'd1,          5'd31, 2, 5, 32'd0,          1'b0, 4};
    tbl[3] = '{3'd0, 7'h11, 32'd100,        32'd23,         5'd1,  8, 1, 32'd123,        1'b0, 10};
    tbl[4] = '{3'd0, 7'h00, 32'd1,          32'd1,          5'd2,  9, 0, 32'd0,          1'b1, 10};
    tbl[5] = '{3'd0, 7'h7F, 32'h1234_5678,  32'h1111_1111,  5'd12, 1, 2, 32'h2345_6789,  1'b0, 3};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst cfu_en", {31'd0, cfu_en_o}, 32'd0);
    chk("rst ops_cnt", ops_cnt_o, 32'd0);
    chk("rst cfu_src1", cfu_src1_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("drain ready 1st cycle", {31'd0, req_ready_o}, 32'd0);
    chk("drain busy", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    chk("drain ready 2nd cycle", {31'd0, req_ready_o}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].f3, tbl[i].f7, tbl[i].s1, tbl[i].s2, tbl[i].rd, tbl[i].lat, tbl[i].hold,
             d, r, e, rl, ne, ok);
      check_op($sformatf("vec%0d", i), d, r, e, rl, ne, ok, tbl[i].xd, tbl[i].rd, tbl[i].xe, tbl[i].xl);
    end

    // CFU stuck busy: watchdog error, then no accept until stall has been low for two cycles
    force_stall = 1'b1;
    run_op(3'd0, 7'h00, 32'd3, 32'd4, 5'd9, 0, 0, d, r, e, rl, ne, ok);
    check_op("stuck", d, r, e, rl, ne, ok, 32'd0, 5'd9, 1'b1, TMO + 2);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (req_ready_o !== 1'b0) ok = 1'b0;
    end
    chk("stuck ready held low", {31'd0, ok}, 32'd1);
    force_stall = 1'b0;
    @(negedge clk);
    chk("stuck ready after 1 quiet", {31'd0, req_ready_o}, 32'd0);
    @(negedge clk);
    chk("stuck ready after 2 quiet", {31'd0, req_ready_o}, 32'd1);

    // reset while waiting on the CFU
    req_valid = 1'b1; req_funct3 = 3'd0; req_funct7 = 7'h00;
    req_src1 = 32'd50; req_src2 = 32'd60; req_rd = 5'd4; resp_lat = 6;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("midrst busy", {31'd0, busy_o}, 32'd0);
    chk("midrst req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("midrst cfu_en", {31'd0, cfu_en_o}, 32'd0);
    chk("midrst cfu_src1", cfu_src1_o, 32'd0);
    chk("midrst ops_cnt", ops_cnt_o, 32'd0);
    exp_ops = 0;
    rst_n = 1'b1;
    k = 0;
    seen = 0;
    while (req_ready_o !== 1'b1 && k < 50) begin
      @(negedge clk);
      if (rsp_valid_o === 1'b1) seen++;
      k++;
    end
    chk("midrst no response", seen, 32'd0);
    run_op(3'd0, 7'h00, 32'd2, 32'd2, 5'd8, 2, 0, d, r, e, rl, ne, ok);
    check_op("post-rst", d, r, e, rl, ne, ok, 32'd4, 5'd8, 1'b0, 4);

    // randomized ops against the latency/result model
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] s1, s2, xd;
      logic [4:0]  rd;
      logic        xe;
      int          lat, hold, xl;
      f3   = 3'($urandom_range(0, 3));
      f7   = 7'($urandom);
      s1   = $urandom;
      s2   = $urandom;
      rd   = 5'($urandom);
      lat  = $urandom_range(0, 11);
      hold = $urandom_range(0, 3);
      xe   = (lat > TMO);
      xl   = xe ? TMO + 2 : lat + 2;
      xd   = xe ? 32'd0 : ((f3 == 3'd0) ? s1 + s2 : 32'd0);
      run_op(f3, f7, s1, s2, rd, lat, hold, d, r, e, rl, ne, ok);
      check_op($sformatf("rnd%0d", i), d, r, e, rl, ne, ok, xd, rd, xe, xl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation still running, expected finish");
    $fatal(1, "global timeout");
  end

endmodule
